// File: rtl/ex_stage.sv
// Execute stage: forwarding muxes, single-cycle ALU and a sequential shift-add
// multiplier that stalls the pipeline while it iterates.
module ex_stage (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] ID_RsData,
    input  logic [31:0] ID_RtData,
    input  logic [31:0] ID_Imm,
    input  logic        ID_ALUSrc,
    input  logic [3:0]  ID_ALUOp,
    input  logic        ID_RegWrite,
    input  logic [4:0]  ID_rd,
    input  logic [1:0]  ForwardA,
    input  logic [1:0]  ForwardB,
    input  logic [31:0] MEM_FwdData,
    input  logic [31:0] WB_FwdData,
    output logic        Stall,
    output logic [31:0] EXMEM_ALUResult,
    output logic [31:0] EXMEM_RtData,
    output logic [4:0]  EXMEM_rd,
    output logic        EXMEM_RegWrite
);

    localparam logic [3:0] OpAdd = 4'b0000;
    localparam logic [3:0] OpSub = 4'b0001;
    localparam logic [3:0] OpAnd = 4'b0010;
    localparam logic [3:0] OpOr  = 4'b0011;
    localparam logic [3:0] OpXor = 4'b0100;
    localparam logic [3:0] OpNor = 4'b0101;
    localparam logic [3:0] OpSlt = 4'b0110;
    localparam logic [3:0] OpSll = 4'b0111;
    localparam logic [3:0] OpSrl = 4'b1000;
    localparam logic [3:0] OpSra = 4'b1001;
    localparam logic [3:0] OpMul = 4'b1010;

    typedef enum logic [1:0] {StIdle, StBusy, StDone} mul_state_e;

    mul_state_e  state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] acc_q, acc_d;
    logic [31:0] mcand_q, mcand_d;
    logic [31:0] mplier_q, mplier_d;
    logic [31:0] rt_q, rt_d;

    logic [31:0] op_a, fwd_b, op_b, alu_result;
    logic [31:0] result_d, rtdata_d;
    logic [4:0]  rd_d;
    logic        regwrite_d;
    logic        stall_int;

    // Select code 11 falls through to the register-file value.
    always_comb begin
        case (ForwardA)
            2'b01:   op_a = MEM_FwdData;
            2'b10:   op_a = WB_FwdData;
            default: op_a = ID_RsData;
        endcase
        case (ForwardB)
            2'b01:   fwd_b = MEM_FwdData;
            2'b10:   fwd_b = WB_FwdData;
            default: fwd_b = ID_RtData;
        endcase
        op_b = ID_ALUSrc ? ID_Imm : fwd_b;
    end

    always_comb begin
        alu_result = 32'd0;
        case (ID_ALUOp)
            OpAdd:   alu_result = op_a + op_b;
            OpSub:   alu_result = op_a - op_b;
            OpAnd:   alu_result = op_a & op_b;
            OpOr:    alu_result = op_a | op_b;
            OpXor:   alu_result = op_a ^ op_b;
            OpNor:   alu_result = ~(op_a | op_b);
            OpSlt:   alu_result = {31'd0, $signed(op_a) < $signed(op_b)};
            OpSll:   alu_result = op_a << op_b[4:0];
            OpSrl:   alu_result = op_a >> op_b[4:0];
            OpSra:   alu_result = $unsigned($signed(op_a) >>> op_b[4:0]);
            default: alu_result = 32'd0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        rt_d       = rt_q;
        stall_int  = 1'b0;
        result_d   = alu_result;
        rtdata_d   = fwd_b;
        rd_d       = ID_rd;
        regwrite_d = ID_RegWrite;

        case (state_q)
            StIdle: begin
                if (ID_ALUOp == OpMul) begin
                    stall_int = 1'b1;
                    state_d   = StBusy;
                    cnt_d     = 5'd0;
                    acc_d     = 32'd0;
                    mcand_d   = op_a;
                    mplier_d  = op_b;
                    rt_d      = fwd_b;
                end
            end
            StBusy: begin
                stall_int = 1'b1;
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                result_d = acc_q;
                rtdata_d = rt_q;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (stall_int) begin
            result_d   = 32'd0;
            rtdata_d   = 32'd0;
            rd_d       = 5'd0;
            regwrite_d = 1'b0;
        end
    end

    assign Stall = stall_int & ~Reset;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q         <= StIdle;
            cnt_q           <= 5'd0;
            acc_q           <= 32'd0;
            mcand_q         <= 32'd0;
            mplier_q        <= 32'd0;
            rt_q            <= 32'd0;
            EXMEM_ALUResult <= 32'd0;
            EXMEM_RtData    <= 32'd0;
            EXMEM_rd        <= 5'd0;
            EXMEM_RegWrite  <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            acc_q           <= acc_d;
            mcand_q         <= mcand_d;
            mplier_q        <= mplier_d;
            rt_q            <= rt_d;
            EXMEM_ALUResult <= result_d;
            EXMEM_RtData    <= rtdata_d;
            EXMEM_rd        <= rd_d;
            EXMEM_RegWrite  <= regwrite_d;
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: expected EX/MEM contents are queued at issue
// and popped when the stage delivers them.
module tb_ex_stage;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [31:0] ID_RsData, ID_RtData, ID_Imm;
    logic        ID_ALUSrc;
    logic [3:0]  ID_ALUOp;
    logic        ID_RegWrite;
    logic [4:0]  ID_rd;
    logic [1:0]  ForwardA, ForwardB;
    logic [31:0] MEM_FwdData, WB_FwdData;
    logic        Stall;
    logic [31:0] EXMEM_ALUResult, EXMEM_RtData;
    logic [4:0]  EXMEM_rd;
    logic        EXMEM_RegWrite;

    typedef struct packed {
        logic [31:0] res;
        logic [31:0] rt;
        logic [4:0]  rd;
        logic        rw;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    ex_stage dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .ID_RsData      (ID_RsData),
        .ID_RtData      (ID_RtData),
        .ID_Imm         (ID_Imm),
        .ID_ALUSrc      (ID_ALUSrc),
        .ID_ALUOp       (ID_ALUOp),
        .ID_RegWrite    (ID_RegWrite),
        .ID_rd          (ID_rd),
        .ForwardA       (ForwardA),
        .ForwardB       (ForwardB),
        .MEM_FwdData    (MEM_FwdData),
        .WB_FwdData     (WB_FwdData),
        .Stall          (Stall),
        .EXMEM_ALUResult(EXMEM_ALUResult),
        .EXMEM_RtData   (EXMEM_RtData),
        .EXMEM_rd       (EXMEM_rd),
        .EXMEM_RegWrite (EXMEM_RegWrite)
    );

    function automatic logic [31:0] fwd(input logic [1:0] sel, input logic [31:0] id,
                                        input logic [31:0] mem, input logic [31:0] wb);
        if (sel == 2'b01) return mem;
        if (sel == 2'b10) return wb;
        return id;
    endfunction

    function automatic logic [31:0] alu_model(input logic [3:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        logic signed [31:0] sa;
        sa = a;
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return ~(a | b);
            4'd6:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd7:    return a << b[4:0];
            4'd8:    return a >> b[4:0];
            4'd9:    return sa >>> b[4:0];
            4'd10:   return a * b;
            default: return 32'd0;
        endcase
    endfunction

    task automatic set_inputs(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                              input logic [31:0] imm, input logic src, input logic [1:0] fa,
                              input logic [1:0] fb, input logic [31:0] memd,
                              input logic [31:0] wbd, input logic [4:0] rd, input logic rw);
        ID_ALUOp = op; ID_RsData = rs; ID_RtData = rt; ID_Imm = imm; ID_ALUSrc = src;
        ForwardA = fa; ForwardB = fb; MEM_FwdData = memd; WB_FwdData = wbd;
        ID_rd = rd; ID_RegWrite = rw;
    endtask

    task automatic compare_out(input string name);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s: result appeared with empty scoreboard", name);
        end else begin
            e = sb.pop_front();
            if ({EXMEM_ALUResult, EXMEM_RtData, EXMEM_rd, EXMEM_RegWrite} !== e) begin
                errors++;
                $display("FAIL %s: got res=%h rt=%h rd=%0d rw=%b, expected res=%h rt=%h rd=%0d rw=%b",
                         name, EXMEM_ALUResult, EXMEM_RtData, EXMEM_rd, EXMEM_RegWrite,
                         e.res, e.rt, e.rd, e.rw);
            end
        end
    endtask

    // Single-cycle op: called right after a rising edge; result checked after the next one.
    task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] rs,
                          input logic [31:0] rt, input logic [31:0] imm, input logic src,
                          input logic [1:0] fa, input logic [1:0] fb, input logic [31:0] memd,
                          input logic [31:0] wbd, input logic [4:0] rd, input logic rw,
                          input logic [31:0] exp_res);
        exp_t e;
        set_inputs(op, rs, rt, imm, src, fa, fb, memd, wbd, rd, rw);
        e.res = exp_res; e.rt = fwd(fb, rt, memd, wbd); e.rd = rd; e.rw = rw;
        sb.push_back(e);
        @(negedge Clk);
        checks++;
        if (Stall !== 1'b0) begin
            errors++;
            $display("FAIL %s_stall: got %b, expected 0", name, Stall);
        end
        @(posedge Clk); #1;
        compare_out(name);
    endtask

    task automatic run_mul(input string name, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] rd, input logic rw, output int done_cyc);
        exp_t e;
        int   n;
        set_inputs(4'd10, a, b, 32'd0, 1'b0, 2'b00, 2'b00, 32'd0, 32'd0, rd, rw);
        e.res = alu_model(4'd10, a, b); e.rt = b; e.rd = rd; e.rw = rw;
        sb.push_back(e);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge Clk);
            if (Stall !== 1'b1) break;
            n++;
            @(posedge Clk); #1;
            checks++;
            if ({EXMEM_ALUResult, EXMEM_RtData, EXMEM_rd, EXMEM_RegWrite} !== 70'd0) begin
                errors++;
                $display("FAIL %s_bubble: got res=%h rt=%h rd=%0d rw=%b, expected all 0",
                         name, EXMEM_ALUResult, EXMEM_RtData, EXMEM_rd, EXMEM_RegWrite);
            end
        end
        checks++;
        if (n != 33) begin
            errors++;
            $display("FAIL %s_stall_cycles: got %0d, expected 33", name, n);
        end
        @(posedge Clk); #1;
        done_cyc = cyc;
        compare_out(name);
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        set_inputs(4'd10, 32'd5, 32'd7, 32'd1, 1'b0, 2'b00, 2'b00, 32'd0, 32'd0, 5'd3, 1'b1);
        @(negedge Clk);
        checks++;
        if (Stall !== 1'b0) begin
            errors++;
            $display("FAIL reset_stall: got %b, expected 0", Stall);
        end
        @(posedge Clk); @(posedge Clk); #1;
        checks++;
        if ({EXMEM_ALUResult, EXMEM_RtData, EXMEM_rd, EXMEM_RegWrite} !== 70'd0) begin
            errors++;
            $display("FAIL reset_outputs: got res=%h rt=%h rd=%0d rw=%b, expected all 0",
                     EXMEM_ALUResult, EXMEM_RtData, EXMEM_rd, EXMEM_RegWrite);
        end
        Reset = 1'b0;
    endtask

    task automatic test_alu();
        run_op("add", 4'd0, 32'd5, 32'd7, 32'd0, 1'b0, 2'b00, 2'b00, 32'd0, 32'd0, 5'd1, 1'b1,
               32'd12);
        run_op("sub_fwd", 4'd1, 32'd0, 32'd0, 32'd0, 1'b0, 2'b01, 2'b10, 32'd100, 32'd30, 5'd2,
               1'b1, 32'd70);
        run_op("sub_fwd11", 4'd1, 32'd50, 32'd0, 32'd0, 1'b0, 2'b11, 2'b10, 32'd100, 32'd30,
               5'd2, 1'b1, 32'd20);
        run_op("sra", 4'd9, 32'h8000_0000, 32'd9, 32'd4, 1'b1, 2'b00, 2'b00, 32'd0, 32'd0, 5'd4,
               1'b1, 32'hF800_0000);
        run_op("slt", 4'd6, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 2'b00, 2'b00, 32'd0, 32'd0, 5'd5,
               1'b1, 32'd1);
        run_op("op1111", 4'd15, 32'd123, 32'd456, 32'd0, 1'b0, 2'b00, 2'b00, 32'd0, 32'd0, 5'd6,
               1'b1, 32'd0);
        run_op("add_wrap", 4'd0, 32'hFFFF_FFFF, 32'd2, 32'd0, 1'b0, 2'b00, 2'b00, 32'd0, 32'd0,
               5'd7, 1'b0, 32'd1);
        for (int i = 0; i < 24; i++) begin
            logic [3:0]  op;
            logic [31:0] rs, rt, imm, memd, wbd;
            logic [1:0]  fa, fb;
            logic        src;
            op = 4'($urandom_range(0, 9)); if (i >= 20) op = 4'($urandom_range(11, 15));
            rs = $urandom; rt = $urandom; imm = $urandom; memd = $urandom; wbd = $urandom;
            fa = 2'($urandom_range(0, 3)); fb = 2'($urandom_range(0, 3));
            src = 1'($urandom_range(0, 1));
            run_op($sformatf("rand%0d_op%0d", i, op), op, rs, rt, imm, src, fa, fb, memd, wbd,
                   5'($urandom_range(0, 31)), 1'b1,
                   alu_model(op, fwd(fa, rs, memd, wbd), src ? imm : fwd(fb, rt, memd, wbd)));
        end
    endtask

    task automatic test_mul();
        int c;
        run_mul("mul_neg", 32'hFFFF_FFFF, 32'd3, 5'd9, 1'b1, c);
        run_mul("mul_rd0", 32'h0001_2345, 32'h0000_1001, 5'd0, 1'b1, c);
    endtask

    task automatic test_back_to_back();
        int c1, c2;
        run_mul("b2b_first", 32'd6, 32'd7, 5'd3, 1'b1, c1);
        run_mul("b2b_second", 32'd2, 32'd3, 5'd4, 1'b1, c2);
        checks++;
        if (c2 - c1 != 34) begin
            errors++;
            $display("FAIL b2b_spacing: got %0d cycles, expected 34", c2 - c1);
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL b2b_scoreboard: %0d entries left, expected 0", sb.size());
        end
    endtask

    task automatic test_reset_abort();
        set_inputs(4'd10, 32'h0000_1234, 32'h10, 32'd0, 1'b0, 2'b00, 2'b00, 32'd0, 32'd0, 5'd5,
                   1'b1);
        @(posedge Clk); #1;
        repeat (10) @(posedge Clk);
        #1;
        Reset = 1'b1;
        @(negedge Clk);
        checks++;
        if (Stall !== 1'b0) begin
            errors++;
            $display("FAIL abort_stall_in_reset: got %b, expected 0", Stall);
        end
        @(posedge Clk); #1;
        Reset = 1'b0;
        set_inputs(4'd15, 32'd0, 32'd0, 32'd0, 1'b0, 2'b00, 2'b00, 32'd0, 32'd0, 5'd0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            @(negedge Clk);
            checks++;
            if (Stall !== 1'b0 ||
                {EXMEM_ALUResult, EXMEM_RtData, EXMEM_rd, EXMEM_RegWrite} !== 70'd0) begin
                errors++;
                $display("FAIL abort_cycle%0d: got stall=%b res=%h rt=%h rd=%0d rw=%b, expected all 0",
                         i, Stall, EXMEM_ALUResult, EXMEM_RtData, EXMEM_rd, EXMEM_RegWrite);
            end
        end
        @(posedge Clk); #1;
    endtask

    initial begin
        test_reset();
        test_alu();
        test_mul();
        test_back_to_back();
        test_reset_abort();
        run_op("after_abort", 4'd3, 32'hF0, 32'h0F, 32'd0, 1'b0, 2'b00, 2'b00, 32'd0, 32'd0,
               5'd8, 1'b1, 32'hFF);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
